pwd_candidate_gen: RTL and testbench

PWD_CANDIDATE_GEN -- requirements
Module: pwd_candidate_gen

---
 rtl/pwd_candidate_gen.sv | 133 +++++++++++++
 tb/tb_pwd_candidate_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwd_candidate_gen.sv
// pwd_candidate_gen: sweeps 8-digit ASCII decimal password candidates across LANES parallel lanes
// Ports: clk/reset_n clock and async active-low reset; start/stop sweep control; base lane-0 start string;
//        cand/lane_active/cand_valid/cand_ready candidate set with valid/ready handshake; busy/done status.
module pwd_candidate_gen #(
  parameter int LANES = 14,
  parameter int BLOCK = 7142858
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [63:0]          base,
  output logic [LANES*64-1:0]  cand,
  output logic [LANES-1:0]     lane_active,
  output logic                 cand_valid,
  input  logic                 cand_ready,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, INIT, ISSUE, DONE} state_t;
  localparam int IW = $clog2(LANES + 1);

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // {carry out of digit 7, 8-digit BCD sum}
  function automatic logic [32:0] bcd_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic c;
    logic [4:0] s;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s = 5'(a[i*4 +: 4]) + 5'(b[i*4 +: 4]) + 5'(c);
      c = s > 5'd9;
      r[i*4 +: 4] = c ? 4'(s - 5'd10) : s[3:0];
    end
    return {c, r};
  endfunction

  localparam logic [31:0] BLOCK_BCD = to_bcd(BLOCK);

  state_t state, state_d;
  logic [IW-1:0] idx;
  logic [26:0] step;
  // acc carries the next lane start value through INIT; acc_ok drops once any add overflowed
  logic [31:0] acc;
  logic acc_ok;
  logic [31:0] lane [LANES];
  logic [31:0] base_bcd;
  logic [32:0] acc_sum;
  logic [32:0] inc [LANES];
  logic [LANES-1:0] next_act;
  logic hs, exhaust;

  assign cand_valid = state == ISSUE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign acc_sum = bcd_add(acc, BLOCK_BCD);
  assign hs = cand_valid && cand_ready && !stop;
  assign exhaust = hs && (step == 27'(BLOCK - 1) || next_act == '0);

  always_comb begin
    base_bcd = '0;
    for (int i = 0; i < 8; i++) base_bcd[i*4 +: 4] = base[i*8 +: 4];
  end

  always_comb begin
    next_act = lane_active;
    for (int i = 0; i < LANES; i++) begin
      inc[i] = bcd_add(lane[i], 32'd1);
      next_act[i] = lane_active[i] & ~inc[i][32];
    end
  end

  always_comb begin
    cand = '0;
    for (int i = 0; i < LANES; i++)
      for (int j = 0; j < 8; j++) cand[i*64 + j*8 +: 8] = {4'h3, lane[i][j*4 +: 4]};
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? INIT : IDLE;
      INIT:    state_d = stop ? IDLE : (idx == IW'(LANES - 1)) ? ISSUE : INIT;
      ISSUE:   state_d = stop ? IDLE : exhaust ? DONE : ISSUE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      step <= '0;
      acc <= '0;
      acc_ok <= 1'b0;
      lane_active <= '0;
      for (int i = 0; i < LANES; i++) lane[i] <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && start) begin
        idx <= '0;
        step <= '0;
        acc <= base_bcd;
        acc_ok <= 1'b1;
        lane_active <= '0;
      end
      if (state == INIT) begin
        lane[idx] <= acc;
        lane_active[idx] <= acc_ok;
        acc <= acc_sum[31:0];
        acc_ok <= acc_ok & ~acc_sum[32];
        idx <= idx + 1'b1;
      end
      if (hs) begin
        for (int i = 0; i < LANES; i++) if (lane_active[i]) lane[i] <= inc[i][31:0];
        lane_active <= next_act;
        step <= step + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pwd_candidate_gen.sv
// tb_pwd_candidate_gen: table, random and corner-sequence checks of pwd_candidate_gen against a decimal model
module tb_pwd_candidate_gen;
  localparam int LANES = 3;
  localparam int BLOCK = 4;
  localparam int BIG_BLOCK = 60000000;

  logic clk = 1'b0;
  logic reset_n, start, stop, cand_ready;
  logic [63:0] base;
  logic [LANES*64-1:0] cand, b_cand;
  logic [LANES-1:0] lane_active, b_act;
  logic cand_valid, busy, done, b_valid, b_busy, b_done;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwd_candidate_gen #(.LANES(LANES), .BLOCK(BLOCK)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .base(base),
    .cand(cand), .lane_active(lane_active), .cand_valid(cand_valid),
    .cand_ready(cand_ready), .busy(busy), .done(done)
  );

  pwd_candidate_gen #(.LANES(LANES), .BLOCK(BIG_BLOCK)) u_big (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .base(base),
    .cand(b_cand), .lane_active(b_act), .cand_valid(b_valid),
    .cand_ready(cand_ready), .busy(b_busy), .done(b_done)
  );

  typedef struct {
    logic [63:0]  base;
    logic [2:0]   act;
    logic [191:0] first;
    int           sets;
  } vec_t;

  task automatic chk(input string nm, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] to_ascii(input longint v);
    logic [63:0] r;
    longint x;
    x = v;
    for (int j = 0; j < 8; j++) begin
      r[j*8 +: 8] = 8'h30 + 8'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic longint from_ascii(input logic [63:0] a);
    longint v;
    v = 0;
    for (int j = 7; j >= 0; j--) v = v * 10 + longint'(a[j*8 +: 8] - 8'h30);
    return v;
  endfunction

  // Lane i after k handshakes holds base + i*BLOCK + k, valid while below 10^8
  task automatic model(input longint bv, input int k, output logic [191:0] ec, output logic [2:0] ea);
    longint s;
    ec = '0;
    for (int i = 0; i < LANES; i++) begin
      s = bv + longint'(i) * BLOCK + k;
      ea[i] = s < 100000000;
      ec[i*64 +: 64] = to_ascii(s % 100000000);
    end
  endtask

  function automatic bit exhausted(input longint bv, input int k);
    if (k == BLOCK) return 1'b1;
    for (int i = 0; i < LANES; i++) if (bv + longint'(i) * BLOCK + k < 100000000) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [191:0] lane_mask(input logic [2:0] a);
    logic [191:0] m;
    for (int i = 0; i < LANES; i++) m[i*64 +: 64] = {64{a[i]}};
    return m;
  endfunction

  task automatic run_sweep(input logic [63:0] b, input int pct, input int stall_at, input bit poke,
                           output logic [191:0] first, output logic [2:0] first_act, output int nsets);
    longint bv;
    int k, stall;
    logic [191:0] ec, m;
    logic [2:0] ea;
    bit fin;
    bv = from_ascii(b);
    k = 0;
    stall = stall_at;
    fin = 1'b0;
    first = '0;
    first_act = '0;
    @(negedge clk);
    base = b;
    start = 1'b1;
    @(negedge clk);
    start = poke;
    if (poke) base = "55555555";
    for (int i = 0; i < LANES; i++) begin
      chk("lat_valid", cand_valid, 0);
      @(negedge clk);
    end
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      model(bv, k, ec, ea);
      m = lane_mask(ea);
      chk("valid", cand_valid, 1);
      chk("act", lane_active, ea);
      chk("cand", cand & m, ec & m);
      if (k == 0) begin
        first = cand;
        first_act = lane_active;
      end
      if (k == stall) begin
        stall = -1;
        cand_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          chk("stall_valid", cand_valid, 1);
          chk("stall_cand", cand & m, ec & m);
        end
      end
      cand_ready = $urandom_range(99) < pct;
      @(negedge clk);
      if (cand_ready) begin
        k++;
        if (exhausted(bv, k)) begin
          start = 1'b0;
          cand_ready = 1'b0;
          chk("done_valid", cand_valid, 0);
          chk("done_pulse", done, 1);
          chk("done_busy", busy, 1);
          @(negedge clk);
          chk("done_end", done, 0);
          chk("idle_busy", busy, 0);
          fin = 1'b1;
        end
      end
    end
    if (!fin) chk("timeout", 0, 1);
    start = 1'b0;
    cand_ready = 1'b0;
    nsets = k;
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_valid"}, cand_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_act"}, lane_active, 0);
    chk({nm, "_cand"}, cand, {LANES{"00000000"}});
  endtask

  initial begin
    vec_t tbl [4];
    logic [191:0] f, m;
    logic [2:0] fa;
    int n;
    longint bv;
    tbl[0] = '{"00000000", 3'b111, {"00000008", "00000004", "00000000"}, 4};
    tbl[1] = '{"99999998", 3'b001, {128'h0, "99999998"}, 2};
    tbl[2] = '{"99999995", 3'b011, {64'h0, "99999999", "99999995"}, 4};
    tbl[3] = '{"00999999", 3'b111, {"01000007", "01000003", "00999999"}, 4};
    reset_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    cand_ready = 1'b0;
    base = '0;
    #1;
    check_reset_vals("rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    base = "00000000";
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LANES) @(negedge clk);
    chk("big_valid", b_valid, 1);
    chk("big_act", b_act, 3'b011);
    chk("big_lane0", b_cand[63:0], "00000000");
    chk("big_lane1", b_cand[127:64], "60000000");
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("big_stop_busy", b_busy, 0);
    for (int t = 0; t < 4; t++) begin
      run_sweep(tbl[t].base, 100, -1, 1'b0, f, fa, n);
      m = lane_mask(tbl[t].act);
      chk("tbl_act", fa, tbl[t].act);
      chk("tbl_first", f & m, tbl[t].first & m);
      chk("tbl_sets", n, tbl[t].sets);
    end
    for (int r = 0; r < 8; r++) begin
      bv = ($urandom_range(2) == 0) ? longint'(99999988 + $urandom_range(11)) : longint'($urandom_range(99999999));
      run_sweep(to_ascii(bv), $urandom_range(100, 30), (r == 2) ? 1 : -1, r == 4, f, fa, n);
    end
    run_sweep("00000000", 100, 2, 1'b1, f, fa, n);
    chk("stall_sets", n, 4);
    @(negedge clk);
    base = "00000000";
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LANES) @(negedge clk);
    chk("sh_valid", cand_valid, 1);
    cand_ready = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    cand_ready = 1'b0;
    chk("sh_valid_low", cand_valid, 0);
    chk("sh_busy", busy, 0);
    chk("sh_done", done, 0);
    @(negedge clk);
    chk("sh_done_after", done, 0);
    base = "12345678";
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (LANES) @(negedge clk);
    cand_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_cand", cand[63:0], "12345680");
    cand_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
